// File: rtl/ac97_pkg.sv
// ============================================================================
// Module : ac97_pkg
// Shared types and widths for the AC97 playback path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ac97_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PRIMING = 2'd1,
    ST_PLAYING = 2'd2
  } state_t;

  localparam int AC97_SAMPLE_W = 20;
  localparam int PCM_IN_W      = 16;
  localparam int PAD_W         = 4;

  // Left-justify a 16-bit PCM sample into a 20-bit AC97 slot.
  function automatic logic [AC97_SAMPLE_W-1:0] to_slot(input logic [PCM_IN_W-1:0] s);
    return {s, {PAD_W{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ac97_fifo_mem.sv
// ============================================================================
// Module : ac97_fifo_mem
// Sample storage: synchronous write, asynchronous read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ac97_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/ac97_playback_fifo.sv
// ============================================================================
// Module : ac97_playback_fifo
// DMA-to-framer playback buffer with priming, refill request and underrun.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ac97_playback_fifo
  import ac97_pkg::*;
#(
  parameter int DEPTH_LOG2    = 4,
  parameter int PRIME_LEVEL   = 4,
  parameter int LOW_WATERMARK = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     wr_stb,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  output logic                     refill_req,
  input  logic                     next_frame,
  output logic                     pcmleft_valid,
  output logic [AC97_SAMPLE_W-1:0] pcmleft,
  output logic                     pcmright_valid,
  output logic [AC97_SAMPLE_W-1:0] pcmright,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     playing,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_PRIME = (DEPTH_LOG2+1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0] LVL_LOW   = (DEPTH_LOG2+1)'(LOW_WATERMARK);

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [31:0]           rd_data;
  logic                  full, empty, push, pop, starve, frame_playing;

  assign full          = (level == LVL_FULL);
  assign empty         = (level == '0);
  assign wr_ready      = !full;
  assign refill_req    = en && (level <= LVL_LOW);

  // flush overrides both sides of the FIFO in the same cycle
  assign push          = wr_stb && !full && !flush;
  assign frame_playing = next_frame && (state == ST_PLAYING);
  assign pop           = frame_playing && !empty && !flush;
  assign starve        = frame_playing && empty && !flush;

  ac97_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (32)
  ) u_mem (
    .clk   (sys_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_STOPPED;
    end else if (flush) begin
      state_nxt = ST_PRIMING;
    end else begin
      case (state)
        ST_STOPPED: state_nxt = ST_PRIMING;
        ST_PRIMING: if (level >= LVL_PRIME) state_nxt = ST_PLAYING;
        ST_PLAYING: if (starve) state_nxt = ST_PRIMING;
        default:    state_nxt = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_STOPPED;
      playing <= 1'b0;
    end else begin
      state   <= state_nxt;
      playing <= (state_nxt == ST_PLAYING);
    end
  end

  // Slot outputs change only on a frame boundary (or flush) and are held otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcmleft_valid  <= 1'b0;
      pcmright_valid <= 1'b0;
      pcmleft        <= '0;
      pcmright       <= '0;
    end else if (flush) begin
      pcmleft_valid  <= 1'b0;
      pcmright_valid <= 1'b0;
      pcmleft        <= '0;
      pcmright       <= '0;
    end else if (next_frame) begin
      if (pop) begin
        pcmleft_valid  <= 1'b1;
        pcmright_valid <= 1'b1;
        pcmleft        <= to_slot(rd_data[31:16]);
        pcmright       <= to_slot(rd_data[15:0]);
      end else begin
        pcmleft_valid  <= 1'b0;
        pcmright_valid <= 1'b0;
        pcmleft        <= '0;
        pcmright       <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underrun <= 1'b0;
    end else if (starve) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire
